fir_filter: RTL

FIR_FILTER -- requirements
Module: fir_filter

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_round_sat.sv | 30 +++
 rtl/fir_filter.sv | 105 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the FIR stage: sample/coefficient/accumulator widths,
// the low-pass coefficient set, the controller state encoding and the tap multiply.
package fir_pkg;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 20;
  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int ACC_W    = 41;
  localparam int FIR_TAPS = 32;

  // Symmetric Q4.16 low-pass; the 32 taps sum to exactly 0x10000 (unity DC gain).
  localparam logic signed [COEF_W-1:0] FIR_COEF [0:FIR_TAPS-1] = '{
    -20'sd120, -20'sd60,  20'sd550,  20'sd800,  20'sd1100, 20'sd1400, 20'sd1700, 20'sd2000,
     20'sd2300, 20'sd2550, 20'sd2800, 20'sd3000, 20'sd3150, 20'sd3600, 20'sd3700, 20'sd4298,
     20'sd4298, 20'sd3700, 20'sd3600, 20'sd3150, 20'sd3000, 20'sd2800, 20'sd2550, 20'sd2300,
     20'sd2000, 20'sd1700, 20'sd1400, 20'sd1100, 20'sd800,  20'sd550, -20'sd60,  -20'sd120
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  function automatic logic signed [PROD_W-1:0] mul_q(input logic signed [DATA_W-1:0] x,
                                                     input logic signed [COEF_W-1:0] h);
    return PROD_W'(x) * PROD_W'(h);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Full-precision accumulator (24 fractional bits) to Q8.8: round half up,
// then clamp to the signed 16-bit range. Purely combinational.
module fir_round_sat
  import fir_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] sat_o
);

  localparam logic signed [ACC_W:0]    HALF  = (ACC_W+1)'(32768);
  localparam logic signed [ACC_W-16:0] MAX_V = (ACC_W-15)'(32767);
  localparam logic signed [ACC_W-16:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W-16:0] shifted;

  always_comb begin
    // one guard bit so the rounding add can never wrap
    rounded = {acc_i[ACC_W-1], acc_i} + HALF;
    shifted = rounded[ACC_W:16];
    if (shifted > MAX_V) begin
      sat_o = 16'sh7FFF;
    end else if (shifted < MIN_V) begin
      sat_o = 16'sh8000;
    end else begin
      sat_o = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR with three register stages (products, sum, round/saturate),
// a valid bit per stage and a single-frame IDLE/RUN/DONE controller.
module fir_filter
  import fir_pkg::*;
#(
  parameter int TAPS      = FIR_TAPS,
  parameter int FRAME_LEN = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  input  logic signed [DATA_W-1:0] data,
  output logic                     fir_valid,
  output logic signed [DATA_W-1:0] fir_d,
  output logic                     fir_done
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  fir_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     accept, flush;
  logic signed [DATA_W-1:0] tap_x  [0:TAPS-1];
  logic signed [DATA_W-1:0] dly_q  [1:TAPS-1];
  logic signed [PROD_W-1:0] prod_q [0:TAPS-1];
  logic signed [ACC_W-1:0]  sum_d, acc_q;
  logic signed [DATA_W-1:0] rnd_sat, fir_d_q;
  logic                     v1_q, v2_q, fir_valid_q;

  assign accept = data_valid && (state_q != DONE);
  assign flush  = fir_valid_q && (state_q == RUN) && (cnt_q == CNT_W'(FRAME_LEN - 1));

  // Tap 0 is the sample being accepted, so its products register on the accepting edge.
  assign tap_x[0] = data;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    if (gi > 0) begin : g_dly
      assign tap_x[gi] = dly_q[gi];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) dly_q[gi] <= '0;
        else if (accept) dly_q[gi] <= tap_x[gi-1];
      end
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) prod_q[gi] <= '0;
      else if (accept) prod_q[gi] <= mul_q(tap_x[gi], FIR_COEF[gi]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
  end

  fir_round_sat u_round_sat (
    .acc_i (acc_q),
    .sat_o (rnd_sat)
  );

  // The frame-closing output squashes whatever is still behind it in the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      fir_valid_q <= 1'b0;
      acc_q       <= '0;
      fir_d_q     <= '0;
    end else begin
      v1_q        <= accept && !flush;
      v2_q        <= v1_q && !flush;
      fir_valid_q <= v2_q && !flush;
      if (v1_q) acc_q <= sum_d;
      if (v2_q && !flush) fir_d_q <= rnd_sat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (flush) state_d = DONE;
        else if (fir_valid_q) cnt_d = cnt_q + 1'b1;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign fir_valid = fir_valid_q;
  assign fir_d     = fir_d_q;
  assign fir_done  = (state_q == DONE);

endmodule
